// File: rtl/input_debouncer_pkg.sv
// Shared widths, default debounce windows and the edge-event record for input_debouncer.
// Latency and backpressure: none (definitions only).
package input_debouncer_pkg;

  localparam int BTN_W             = 4;
  localparam int SW_W              = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_BTN_DB_CYCLES = 50000;   // 1 ms at 50 MHz
  localparam int DEF_SW_DB_CYCLES  = 500000;  // 10 ms at 50 MHz

  typedef struct packed {
    logic press;  // debounced 1->0
    logic rel;    // debounced 0->1
  } ev_t;

endpackage

// File: rtl/input_debouncer_ch.sv
// One channel: SYNC_STAGES sync flops, stability counter, db register (+ edge registers with INPUT_DEBOUNCER_EVENT_EN).
// Latency SYNC_STAGES+DB_CYCLES cycles pin-to-db, events one cycle later; no backpressure.
module debounce_ch
  import input_debouncer_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   DB_CYCLES   = DEF_BTN_DB_CYCLES,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic db_o
`ifdef INPUT_DEBOUNCER_EVENT_EN
  ,
  output ev_t  ev_o,
  output logic ev_d_o
`endif
);

  localparam int            CW   = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    if (sync_lvl == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      db_d  = sync_lvl;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= '0;
      db_q   <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign db_o = db_q;

`ifdef INPUT_DEBOUNCER_EVENT_EN
  logic prev_q;
  ev_t  ev_q, ev_d;

  always_comb begin
    ev_d       = '0;
    ev_d.press = prev_q & ~db_q;
    ev_d.rel   = ~prev_q & db_q;
  end

  // prev resets to the same level as db so the reset load never looks like an edge
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= RESET_VAL;
      ev_q   <= '0;
    end else begin
      prev_q <= db_q;
      ev_q   <= ev_d;
    end
  end

  assign ev_o   = ev_q;
  assign ev_d_o = ev_d.press | ev_d.rel;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Debounces 4 KEY and 4 SW pins for the soc_system PIOs; edge pulses and event_any only with INPUT_DEBOUNCER_EVENT_EN.
// Latency SYNC_STAGES+*_DB_CYCLES cycles to db, pulses one cycle later; no backpressure.
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int               SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int               BTN_DB_CYCLES = DEF_BTN_DB_CYCLES,
  parameter int               SW_DB_CYCLES  = DEF_SW_DB_CYCLES,
  parameter logic [BTN_W-1:0] BTN_RESET_VAL = 4'hF,
  parameter logic [SW_W-1:0]  SW_RESET_VAL  = 4'h0
) (
  input  logic             clk_clk,
  input  logic             reset,
  input  logic [BTN_W-1:0] btn_raw,
  input  logic [SW_W-1:0]  sw_raw,
  output logic [BTN_W-1:0] btn_db,
  output logic [SW_W-1:0]  sw_db,
  output logic [BTN_W-1:0] btn_press,
  output logic [BTN_W-1:0] btn_release,
  output logic [SW_W-1:0]  sw_change,
  output logic             event_any
);

`ifdef INPUT_DEBOUNCER_EVENT_EN
  ev_t              btn_ev [BTN_W];
  ev_t              sw_ev  [SW_W];
  logic [BTN_W-1:0] btn_ev_d;
  logic [SW_W-1:0]  sw_ev_d;
  logic             event_any_q;
`endif

  for (genvar i = 0; i < BTN_W; i++) begin : g_btn
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (BTN_DB_CYCLES),
      .RESET_VAL   (BTN_RESET_VAL[i])
    ) u_ch (
      .clk_i   (clk_clk),
      .reset_i (reset),
      .raw_i   (btn_raw[i]),
      .db_o    (btn_db[i])
`ifdef INPUT_DEBOUNCER_EVENT_EN
      ,
      .ev_o    (btn_ev[i]),
      .ev_d_o  (btn_ev_d[i])
`endif
    );
`ifdef INPUT_DEBOUNCER_EVENT_EN
    assign btn_press[i]   = btn_ev[i].press;
    assign btn_release[i] = btn_ev[i].rel;
`endif
  end

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (SW_DB_CYCLES),
      .RESET_VAL   (SW_RESET_VAL[i])
    ) u_ch (
      .clk_i   (clk_clk),
      .reset_i (reset),
      .raw_i   (sw_raw[i]),
      .db_o    (sw_db[i])
`ifdef INPUT_DEBOUNCER_EVENT_EN
      ,
      .ev_o    (sw_ev[i]),
      .ev_d_o  (sw_ev_d[i])
`endif
    );
`ifdef INPUT_DEBOUNCER_EVENT_EN
    assign sw_change[i] = sw_ev[i].press | sw_ev[i].rel;
`endif
  end

`ifdef INPUT_DEBOUNCER_EVENT_EN
  // Built from the same next-state terms as the per-channel pulses so it lands in their cycle
  always_ff @(posedge clk_clk) begin
    if (reset) begin
      event_any_q <= 1'b0;
    end else begin
      event_any_q <= |{btn_ev_d, sw_ev_d};
    end
  end

  assign event_any = event_any_q;
`else
  assign btn_press   = '0;
  assign btn_release = '0;
  assign sw_change   = '0;
  assign event_any   = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with BTN_DB_CYCLES=8, SW_DB_CYCLES=16, SYNC_STAGES=2.
module tb_input_debouncer;

`ifdef INPUT_DEBOUNCER_EVENT_EN
  localparam bit EV_EN = 1'b1;
`else
  localparam bit EV_EN = 1'b0;
`endif
  localparam logic [3:0] PM = {4{EV_EN}};

  logic       clk_clk = 1'b0;
  logic       reset;
  logic [3:0] btn_raw, sw_raw;
  logic [3:0] btn_db, sw_db, btn_press, btn_release, sw_change;
  logic       event_any;

  int ncmp  = 0;
  int nfail = 0;

  always #5 clk_clk = ~clk_clk;

  input_debouncer #(
    .SYNC_STAGES   (2),
    .BTN_DB_CYCLES (8),
    .SW_DB_CYCLES  (16),
    .BTN_RESET_VAL (4'hF),
    .SW_RESET_VAL  (4'h0)
  ) dut (
    .clk_clk     (clk_clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .btn_db      (btn_db),
    .sw_db       (sw_db),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .sw_change   (sw_change),
    .event_any   (event_any)
  );

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] sw;
    int         n;
    logic [3:0] e_btn;
    logic [3:0] e_sw;
    logic [3:0] e_prs;
    logic [3:0] e_rel;
    logic [3:0] e_chg;
    logic       e_any;
  } vec_t;

  vec_t vecs [19];

  task automatic step(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    // reset 3 cycles with keys low, release, keys low commit at cycle 10
    vecs[0]  = '{1'b1, 4'h0, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 4'h0,  2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[2]  = '{1'b0, 4'h0, 4'h0,  9, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[3]  = '{1'b0, 4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    // all keys released
    vecs[4]  = '{1'b0, 4'hF, 4'h0,  9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[5]  = '{1'b0, 4'hF, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[6]  = '{1'b0, 4'hF, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1};
    vecs[7]  = '{1'b0, 4'hF, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    // clean press of key 1
    vecs[8]  = '{1'b0, 4'hD, 4'h0,  9, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[9]  = '{1'b0, 4'hD, 4'h0,  1, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[10] = '{1'b0, 4'hD, 4'h0,  1, 4'hD, 4'h0, 4'h2, 4'h0, 4'h0, 1'b1};
    vecs[11] = '{1'b0, 4'hD, 4'h0,  1, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    // key 1 released
    vecs[12] = '{1'b0, 4'hF, 4'h0, 10, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[13] = '{1'b0, 4'hF, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1};
    vecs[14] = '{1'b0, 4'hF, 4'h0,  1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    // two switches commit together at cycle 18
    vecs[15] = '{1'b0, 4'hF, 4'hA, 17, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[16] = '{1'b0, 4'hF, 4'hA,  1, 4'hF, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0};
    vecs[17] = '{1'b0, 4'hF, 4'hA,  1, 4'hF, 4'hA, 4'h0, 4'h0, 4'hA, 1'b1};
    vecs[18] = '{1'b0, 4'hF, 4'hA,  1, 4'hF, 4'hA, 4'h0, 4'h0, 4'h0, 1'b0};

    reset   = 1'b1;
    btn_raw = 4'h0;
    sw_raw  = 4'h0;

    for (int i = 0; i < 19; i++) begin
      reset   = vecs[i].rst;
      btn_raw = vecs[i].btn;
      sw_raw  = vecs[i].sw;
      step(vecs[i].n);
      chk($sformatf("v%0d btn_db", i),      btn_db,             vecs[i].e_btn);
      chk($sformatf("v%0d sw_db", i),       sw_db,              vecs[i].e_sw);
      chk($sformatf("v%0d btn_press", i),   btn_press,          vecs[i].e_prs & PM);
      chk($sformatf("v%0d btn_release", i), btn_release,        vecs[i].e_rel & PM);
      chk($sformatf("v%0d sw_change", i),   sw_change,          vecs[i].e_chg & PM);
      chk($sformatf("v%0d event_any", i),   {3'b000, event_any}, {3'b000, vecs[i].e_any & EV_EN});
    end

    // key 2 bounces with 3-cycle runs, then settles low
    for (int k = 0; k < 14; k++) begin
      btn_raw = (k % 2 == 1) ? 4'hF : 4'hB;
      for (int c = 0; c < 3; c++) begin
        step(1);
        chk("bounce_hold btn_db", btn_db, 4'hF);
        chk("bounce_hold press", btn_press, 4'h0);
      end
    end
    btn_raw = 4'hB;
    step(9);
    chk("bounce_settle_c9 btn_db", btn_db, 4'hF);
    step(1);
    chk("bounce_settle_c10 btn_db", btn_db, 4'hB);
    step(1);
    chk("bounce_press", btn_press, 4'h4 & PM);
    chk("bounce_event_any", {3'b000, event_any}, {3'b000, EV_EN});

    // 15-cycle switch glitch is one short of the 16-cycle window
    sw_raw = 4'hB;
    for (int c = 0; c < 15; c++) begin
      step(1);
      chk("glitch sw_db", sw_db, 4'hA);
      chk("glitch sw_change", sw_change, 4'h0);
    end
    sw_raw = 4'hA;
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("glitch_after sw_db", sw_db, 4'hA);
      chk("glitch_after sw_change", sw_change, 4'h0);
    end

    // press key 0 (key 2 still held), reset when its counter has reached 5
    btn_raw = 4'hA;
    step(7);
    chk("midpend_pre btn_db", btn_db, 4'hB);
    reset = 1'b1;
    step(1);
    chk("midpend_rst btn_db", btn_db, 4'hF);
    chk("midpend_rst sw_db", sw_db, 4'h0);
    chk("midpend_rst release", btn_release, 4'h0);
    reset = 1'b0;
    step(1);
    chk("midpend_c1 release", btn_release, 4'h0);
    chk("midpend_c1 change", sw_change, 4'h0);
    chk("midpend_c1 event_any", {3'b000, event_any}, 4'h0);
    step(8);
    chk("midpend_c9 btn_db", btn_db, 4'hF);
    step(1);
    chk("midpend_c10 btn_db", btn_db, 4'hA);
    step(1);
    chk("midpend_c11 press", btn_press, 4'h5 & PM);
    step(1);
    chk("midpend_c12 press", btn_press, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
